// File: rtl/result_readback_pkg.sv
// Shared sizes and types for the result readback stage.
package result_readback_pkg;

    localparam int RESULT_SIZE = 32;
    localparam int ADDR_SIZE   = 16;
    localparam int S2P_SIZE    = 8;
    localparam int SHIFT_SIZE  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rr_state_e;

endpackage

// File: rtl/result_readback_fifo.sv
// Small synchronous FIFO holding requantised words plus their last tag.
module rr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == CW'(DEPTH));
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Writing into a full FIFO is only accepted when the head leaves in the same cycle.
    always_comb begin
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + (do_push ? CW'(1) : CW'(0));
        rd_ptr_d = rd_ptr_q + (do_pop ? CW'(1) : CW'(0));
    end

    // Pointer and storage update; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/result_readback.sv
// Reads the result memory after the write stage finishes, requantises each
// word (ReLU, rounding shift, saturation) and streams it out on valid/ready.
module result_readback
    import result_readback_pkg::*;
#(
    parameter int RESULT_W   = RESULT_SIZE,
    parameter int ADDR_W     = ADDR_SIZE,
    parameter int OUT_W      = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  w_done,
    input  logic [ADDR_W-1:0]     total_words,
    input  logic [SHIFT_SIZE-1:0] shift,
    input  logic                  relu_en,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [RESULT_W-1:0]   rd_data,
    output logic [OUT_W-1:0]      o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [RESULT_W:0] SAT_MAX = (RESULT_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [RESULT_W:0] SAT_MIN = ~SAT_MAX;

    rr_state_e             state_q;
    logic                  w_done_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_W-1:0]     total_q;
    logic [SHIFT_SIZE-1:0] shift_q;
    logic                  relu_q;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [RD_LAT-1:0]     vpipe_q;
    logic [RD_LAT-1:0]     lpipe_q;

    logic                  start;
    logic                  issue_last;
    logic                  ret_valid;
    logic                  ret_last;
    logic                  pop;
    logic                  final_hs;
    logic [CW:0]           slots_used;
    logic                  credit_ok;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OUT_W:0]        fifo_head;

    logic signed [RESULT_W:0] x_ext;
    logic signed [RESULT_W:0] round_c;
    logic signed [RESULT_W:0] y_sum;
    logic signed [RESULT_W:0] y_shift;
    logic [OUT_W-1:0]         q_word;

    assign ret_valid = vpipe_q[RD_LAT-1];
    assign ret_last  = lpipe_q[RD_LAT-1];
    assign o_valid   = !fifo_empty;
    assign o_data    = fifo_head[OUT_W-1:0];
    assign o_last    = fifo_head[OUT_W];
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_addr   = rd_addr_q;

    // Start detection, credit check and read issue. A slot being popped this
    // cycle is counted as free, which keeps full throughput at the minimum depth
    // while every issued read still has a guaranteed FIFO slot.
    always_comb begin
        start      = w_done && !w_done_q && (state_q == ST_IDLE);
        pop        = o_valid && o_ready;
        final_hs   = pop && o_last;
        slots_used = {1'b0, fifo_count} + {1'b0, inflight_q} - (pop ? (CW+1)'(1) : (CW+1)'(0));
        credit_ok  = slots_used < (CW+1)'(FIFO_DEPTH);
        rd_en      = (state_q == ST_READ) && credit_ok;
        issue_last = rd_en && (rd_addr_q == total_q - ADDR_W'(1));
        rd_addr_d  = rd_addr_q;
        if (start) begin
            rd_addr_d = '0;
        end else if (rd_en) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        inflight_d = inflight_q + (rd_en ? CW'(1) : CW'(0)) - (ret_valid ? CW'(1) : CW'(0));
    end

    // Requantisation of the returning word: ReLU, rounding arithmetic shift, saturation.
    always_comb begin
        x_ext = {rd_data[RESULT_W-1], rd_data};
        if (relu_q && rd_data[RESULT_W-1]) begin
            x_ext = '0;
        end
        round_c = '0;
        if (shift_q != '0) begin
            round_c = (RESULT_W+1)'(1) << (shift_q - SHIFT_SIZE'(1));
        end
        y_sum   = x_ext + round_c;
        y_shift = y_sum >>> shift_q;
        if (y_shift > SAT_MAX) begin
            q_word = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (y_shift < SAT_MIN) begin
            q_word = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            q_word = y_shift[OUT_W-1:0];
        end
    end

    // Control FSM with registered busy/done; run parameters are captured on start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            w_done_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            total_q  <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
        end else begin
            w_done_q <= w_done;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        total_q <= total_words;
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        if (total_words == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (final_hs) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read address, in-flight counter and the return-marking valid/last pipe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_q  <= '0;
            inflight_q <= '0;
            vpipe_q    <= '0;
            lpipe_q    <= '0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
            vpipe_q[0] <= rd_en;
            lpipe_q[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
                lpipe_q[i] <= lpipe_q[i-1];
            end
        end
    end

    rr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (ret_valid),
        .wdata_i ({ret_last, q_word}),
        .pop_i   (o_ready),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The credit scheme keeps pushes from ever meeting a full FIFO without a pop.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_result_readback.sv
// Self-checking bench for result_readback: two instances (read latency 1 and 3)
// share stimulus; results are compared with a behavioural requantisation model.
module tb_result_readback;

    localparam int DEPTH = 4;
    localparam int MAXW  = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wDone = 1'b0;
    logic [15:0] totalWords = '0;
    logic [4:0]  shiftAmt = '0;
    logic        reluEn = 1'b0;
    logic        oReady = 1'b1;

    logic        rdEn   [2];
    logic [15:0] rdAddr [2];
    logic [31:0] rdData [2];
    logic [7:0]  oData  [2];
    logic        oValid [2];
    logic        oLast  [2];
    logic        busy   [2];
    logic        done   [2];

    logic [31:0] mem [256];
    logic [31:0] lat3S1, lat3S2;

    int totalChecks = 0;
    int badChecks   = 0;
    int cycCnt      = 0;
    int readyMode   = 0;
    int startEdge   = 0;
    int latOf [2]   = '{1, 3};

    logic [7:0] gotData [2][MAXW];
    logic       gotLast [2][MAXW];
    int  gotCnt [2], doneCnt [2], doneCyc [2], firstValidCyc [2];
    int  firstHsCyc [2], lastHsCyc [2], issued [2], popped [2];
    bit  validSeen [2], prevStall [2];
    logic [7:0] prevData [2];
    logic       prevLast [2];

    always #5 clk = ~clk;

    result_readback #(.RD_LAT(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .w_done(wDone), .total_words(totalWords),
        .shift(shiftAmt), .relu_en(reluEn), .rd_en(rdEn[0]), .rd_addr(rdAddr[0]),
        .rd_data(rdData[0]), .o_data(oData[0]), .o_valid(oValid[0]), .o_ready(oReady),
        .o_last(oLast[0]), .busy(busy[0]), .done(done[0])
    );

    result_readback #(.RD_LAT(3), .FIFO_DEPTH(DEPTH)) dut3 (
        .clk(clk), .rstn(rstn), .w_done(wDone), .total_words(totalWords),
        .shift(shiftAmt), .relu_en(reluEn), .rd_en(rdEn[1]), .rd_addr(rdAddr[1]),
        .rd_data(rdData[1]), .o_data(oData[1]), .o_valid(oValid[1]), .o_ready(oReady),
        .o_last(oLast[1]), .busy(busy[1]), .done(done[1])
    );

    // BRAM port-B models with one and three cycles of read latency.
    always @(posedge clk) begin
        if (rdEn[0]) rdData[0] <= mem[rdAddr[0][7:0]];
        if (rdEn[1]) lat3S1 <= mem[rdAddr[1][7:0]];
        lat3S2    <= lat3S1;
        rdData[1] <= lat3S2;
    end

    // Free-running edge counter used for latency measurements.
    always @(posedge clk) cycCnt <= cycCnt + 1;

    // Downstream ready: always on, the 1,0,0,1 pattern, or random.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       oReady = 1'b1;
            1:       oReady = ((cycCnt % 4) == 0) || ((cycCnt % 4) == 3);
            default: oReady = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        assert (got === exp) else begin
            badChecks++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural requantisation: ReLU, round-half-up shift, clamp to int8.
    function automatic logic [7:0] refWord(input logic [31:0] raw, input int sh, input bit relu);
        longint x, y;
        x = longint'($signed(raw));
        if (relu && x < 0) x = 0;
        if (sh > 0) y = (x + (longint'(1) << (sh - 1))) >>> sh;
        else        y = x;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y[7:0];
    endfunction

    // Per-cycle observation of both instances: handshakes, stalls, credits, done pulses.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                issued[k] = 0;
                popped[k] = 0;
                prevStall[k] = 1'b0;
            end else begin
                if (prevStall[k]) begin
                    checkOutput($sformatf("stallValid%0d", k), 64'(oValid[k]), 64'(1));
                    checkOutput($sformatf("stallData%0d", k), 64'(oData[k]), 64'(prevData[k]));
                    checkOutput($sformatf("stallLast%0d", k), 64'(oLast[k]), 64'(prevLast[k]));
                end
                if (rdEn[k]) begin
                    checkOutput($sformatf("credit%0d", k),
                                64'(issued[k] - popped[k] - ((oValid[k] && oReady) ? 1 : 0) < DEPTH), 64'(1));
                    checkOutput($sformatf("rdAddr%0d", k), 64'(rdAddr[k]), 64'(issued[k][15:0]));
                    issued[k]++;
                end
                if (oValid[k]) begin
                    validSeen[k] = 1'b1;
                    if (firstValidCyc[k] < 0) firstValidCyc[k] = cycCnt;
                end
                if (oValid[k] && oReady) begin
                    if (gotCnt[k] < MAXW) begin
                        gotData[k][gotCnt[k]] = oData[k];
                        gotLast[k][gotCnt[k]] = oLast[k];
                    end
                    if (gotCnt[k] == 0) firstHsCyc[k] = cycCnt;
                    lastHsCyc[k] = cycCnt;
                    gotCnt[k]++;
                    popped[k]++;
                end
                if (done[k]) begin
                    doneCnt[k]++;
                    doneCyc[k] = cycCnt;
                end
                prevStall[k] = oValid[k] && !oReady;
                prevData[k]  = oData[k];
                prevLast[k]  = oLast[k];
            end
        end
    end

    task automatic clearRun();
        for (int k = 0; k < 2; k++) begin
            gotCnt[k] = 0; doneCnt[k] = 0; doneCyc[k] = -1; firstValidCyc[k] = -1;
            firstHsCyc[k] = -1; lastHsCyc[k] = -1; issued[k] = 0; popped[k] = 0;
            validSeen[k] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int total, input int sh, input bit relu, input int mode, input int hold);
        int budget;
        @(negedge clk); #1;
        clearRun();
        readyMode  = mode;
        totalWords = 16'(total);
        shiftAmt   = 5'(sh);
        reluEn     = relu;
        startEdge  = cycCnt + 1;
        wDone      = 1'b1;
        repeat (hold) begin @(negedge clk); #1; end
        wDone = 1'b0;
        budget = 0;
        while (!(doneCnt[0] >= 1 && doneCnt[1] >= 1) && budget < 3000) begin
            @(negedge clk); #1;
            budget++;
        end
        checkOutput("runTimeout", 64'(budget >= 3000), 64'(0));
        repeat (4) begin @(negedge clk); #1; end
    endtask

    task automatic verifyRun(input string name, input int total, input int sh, input bit relu, input int mode);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s_count%0d", name, k), 64'(gotCnt[k]), 64'(total));
            for (int i = 0; i < total && i < gotCnt[k] && i < MAXW; i++) begin
                checkOutput($sformatf("%s_data%0d_%0d", name, k, i), 64'(gotData[k][i]), 64'(refWord(mem[i], sh, relu)));
                checkOutput($sformatf("%s_last%0d_%0d", name, k, i), 64'(gotLast[k][i]), 64'(i == total - 1));
            end
            checkOutput($sformatf("%s_doneCnt%0d", name, k), 64'(doneCnt[k]), 64'(1));
            if (total > 0) begin
                checkOutput($sformatf("%s_doneCyc%0d", name, k), 64'(doneCyc[k]), 64'(lastHsCyc[k] + 1));
            end else begin
                checkOutput($sformatf("%s_doneCyc%0d", name, k), 64'(doneCyc[k]), 64'(startEdge));
                checkOutput($sformatf("%s_noValid%0d", name, k), 64'(validSeen[k]), 64'(0));
                checkOutput($sformatf("%s_noRead%0d", name, k), 64'(issued[k]), 64'(0));
            end
            if (mode == 0 && total > 0) begin
                checkOutput($sformatf("%s_latency%0d", name, k), 64'(firstValidCyc[k] - startEdge), 64'(latOf[k] + 1));
                checkOutput($sformatf("%s_backToBack%0d", name, k), 64'(lastHsCyc[k] - firstHsCyc[k]), 64'(total - 1));
            end
        end
    endtask

    task automatic checkResetOutputs(input string name);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s_rdEn%0d", name, k), 64'(rdEn[k]), 64'(0));
            checkOutput($sformatf("%s_rdAddr%0d", name, k), 64'(rdAddr[k]), 64'(0));
            checkOutput($sformatf("%s_oValid%0d", name, k), 64'(oValid[k]), 64'(0));
            checkOutput($sformatf("%s_oData%0d", name, k), 64'(oData[k]), 64'(0));
            checkOutput($sformatf("%s_oLast%0d", name, k), 64'(oLast[k]), 64'(0));
            checkOutput($sformatf("%s_busy%0d", name, k), 64'(busy[k]), 64'(0));
            checkOutput($sformatf("%s_done%0d", name, k), 64'(done[k]), 64'(0));
        end
    endtask

    task automatic fillRandom(input int n);
        int v;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = int'($urandom_range(0, 4000)) - 2000;
                mem[i] = v;
            end else begin
                mem[i] = $urandom;
            end
        end
    endtask

    logic [7:0] expA [4];
    int budget;

    initial begin
        $display("[TB] start");
        for (int i = 0; i < 256; i++) mem[i] = '0;
        clearRun();
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        mem[0] = 32'd100; mem[1] = -32'sd5; mem[2] = 32'd300; mem[3] = -32'sd300;
        applyStimulus(4, 0, 1'b0, 0, 1);
        verifyRun("plain", 4, 0, 1'b0, 0);
        expA[0] = 8'd100; expA[1] = 8'hFB; expA[2] = 8'd127; expA[3] = 8'h80;
        for (int i = 0; i < 4; i++) checkOutput($sformatf("plainConst_%0d", i), 64'(gotData[0][i]), 64'(expA[i]));

        applyStimulus(4, 2, 1'b1, 0, 1);
        verifyRun("relu", 4, 2, 1'b1, 0);
        expA[0] = 8'd25; expA[1] = 8'd0; expA[2] = 8'd75; expA[3] = 8'd0;
        for (int i = 0; i < 4; i++) checkOutput($sformatf("reluConst_%0d", i), 64'(gotData[1][i]), 64'(expA[i]));

        mem[0] = 32'd6; mem[1] = 32'd5; mem[2] = -32'sd6; mem[3] = 32'd7;
        applyStimulus(4, 2, 1'b0, 0, 1);
        verifyRun("round", 4, 2, 1'b0, 0);
        checkOutput("roundConst6", 64'(gotData[0][0]), 64'(2));
        checkOutput("roundConst5", 64'(gotData[0][1]), 64'(1));

        fillRandom(16);
        applyStimulus(16, 3, 1'b0, 1, 1);
        verifyRun("toggle", 16, 3, 1'b0, 1);

        applyStimulus(0, 0, 1'b0, 0, 3);
        verifyRun("empty", 0, 0, 1'b0, 0);

        mem[0] = 32'd100; mem[1] = -32'sd5; mem[2] = 32'd300; mem[3] = -32'sd300;
        applyStimulus(4, 0, 1'b0, 0, 50);
        verifyRun("hold", 4, 0, 1'b0, 0);

        fillRandom(8);
        applyStimulus(8, 5, 1'b1, 0, 1);
        verifyRun("stream", 8, 5, 1'b1, 0);

        fillRandom(24);
        applyStimulus(24, 9, 1'b0, 2, 2);
        verifyRun("random", 24, 9, 1'b0, 2);

        fillRandom(16);
        @(negedge clk); #1;
        clearRun();
        readyMode = 0; totalWords = 16'd16; shiftAmt = 5'd1; reluEn = 1'b0;
        wDone = 1'b1;
        @(negedge clk); #1;
        wDone = 1'b0;
        budget = 0;
        while (gotCnt[0] < 5 && budget < 200) begin @(negedge clk); #1; budget++; end
        checkOutput("midTimeout", 64'(budget >= 200), 64'(0));
        checkOutput("midBusy", 64'(busy[0]), 64'(1));
        rstn = 1'b0;
        @(negedge clk); #1;
        checkResetOutputs("midReset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        fillRandom(16);
        applyStimulus(16, 4, 1'b1, 1, 1);
        verifyRun("afterReset", 16, 4, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
